load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- CPU-side initiator for the word-wide data memory port (clk, addr, write_data, memwrite, memread, sign_mask, read_data).
- Accepts RV32I load/store requests from the execute stage and issues word-indexed memory cycles.
- Performs read-modify-write for SB/SH, because the memory writes whole words only.
- Extracts and sign/zero-extends load data, flags misaligned, illegal or out-of-range accesses, and returns a single response per request.

Parameters:
- MEM_WORDS, 8192, number of 32-bit words backed by data memory; valid word index 0..MEM_WORDS-1.
- MMIO_WORD_ADDR, 32'h2000, word index of the LED register; legal even though it is >= MEM_WORDS.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/half used for SB/SH.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  misaligned, illegal funct3 or out of range.
- mem_addr  output  32  word index = {2'b00, byte_addr[31:2]}.
- mem_write_data  output  32  word to write.
- mem_memwrite  output  1  write strobe.
- mem_memread  output  1  read strobe.
- mem_sign_mask  output  4  byte-lane mask of the access; 4'b0000 when no strobe.
- mem_read_data  input  32  memory read data, valid the cycle after mem_memread.

Behaviour:
- All mem_* outputs and resp_* outputs are registered.
- Reset values: mem_memread=0, mem_memwrite=0, mem_sign_mask=0, mem_addr=0, mem_write_data=0, resp_valid=0, resp_rdata=0, resp_error=0, state=IDLE (req_ready=1).
- Accept handshake: req_valid && req_ready at a rising edge. The request is latched, so inputs may change afterwards.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an error.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Out of range: word index >= MEM_WORDS and != MMIO_WORD_ADDR.
- States and transitions:
  - IDLE: on accept:
    - error -> RESP with resp_error=1, no memory strobe.
    - load or SB/SH -> RD (assert mem_memread, mem_addr, mem_sign_mask).
    - SW -> WR (mem_memwrite=1, mem_write_data=req_wdata, mask 4'b1111).
  - RD: strobe drops; if load -> LCAP, else -> MERGE.
  - LCAP: mem_read_data valid. Select lane by addr[1:0] (byte) or addr[1] (half), extend per funct3, register into resp_rdata -> RESP.
  - MERGE: replace the target lane(s) of mem_read_data with req_wdata[7:0] or [15:0]. Drive mem_memwrite=1 with the merged word and mask -> WR.
  - WR: strobe drops -> RESP.
  - RESP: resp_valid=1; hold resp_valid/resp_rdata/resp_error stable until resp_ready, then -> IDLE (resp_valid=0).
- Latency from accept edge to resp_valid high:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Load: 3 cycles.
  - SB/SH: 4 cycles.
- Strobes are single-cycle pulses; mem_memread and mem_memwrite are never high together.
- No new request is accepted until the response handshake completes. A new request may be accepted in the cycle after resp_ready.
- Reset mid-operation: immediate return to IDLE. Strobes drop asynchronously and a partial RMW write is abandoned; memory is unmodified if reset asserts before the WR strobe edge.

Test Plan:
- Mem word 0x10 = 0x8899AABB; LB addr 0x41 -> mem_addr=0x10, mask 4'b0010, resp_rdata=0xFFFFFFAA at accept+3, error=0.
- Same word; LHU addr 0x42 -> resp_rdata=0x00008899; LW addr 0x40 -> 0x8899AABB.
- SB addr 0x43 wdata 0x12345677 -> one read pulse, then one write pulse with mem_write_data=0x7799AABB and mask 4'b1000; a subsequent LW returns 0x7799AABB.
- SW addr 0x8000 wdata 0x000000A5 (MMIO) -> mem_addr=0x2000, memwrite pulse, resp at accept+2, error=0, LED=0xA5.
- LW addr 0x42, LH addr 0x41, funct3=011 and LW addr 0x8004 -> each resp_error=1 at accept+1, resp_rdata=0, no strobe.
- resp_ready held low 5 cycles -> resp_valid/rdata stable and req_ready=0. Reset asserted during MERGE -> strobes 0 immediately, memory unchanged, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store initiator for a word-wide data memory. Decodes and range-checks
//          each request, does read-modify-write for SB/SH, and extends load data.
// Ports:   req_* execute-stage request (valid/ready), resp_* single response per request
//          (valid/ready), mem_* registered word-indexed memory strobes, clk/reset (async, high).
// Latency: accept edge to resp_valid: error 1, SW 2, load 3, SB/SH 4 cycles.
// Backpressure: req_ready is high only in IDLE; the response is held until resp_ready.
module load_store_unit #(
    parameter int unsigned MEM_WORDS      = 8192,
    parameter logic [31:0] MMIO_WORD_ADDR = 32'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LCAP  = 3'd2,
        S_MERGE = 3'd3,
        S_WR    = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Request fields latched at accept so the requester may move on.
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;

    logic        w_accept;
    logic [31:0] w_req_word;
    logic        w_f3_ok;
    logic        w_misal;
    logic        w_oor;
    logic        w_err;
    logic        w_is_sw;
    logic [3:0]  w_req_mask;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign req_ready  = (r_state == S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_req_word = {2'b00, req_addr[31:2]};

    // ---------------- request decode ----------------
    always_comb begin
        w_f3_ok = 1'b0;
        if (req_store) begin
            w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oor   = (w_req_word >= 32'(MEM_WORDS)) && (w_req_word != MMIO_WORD_ADDR);
    assign w_err   = !w_f3_ok || w_misal || w_oor;
    assign w_is_sw = req_store && (req_funct3[1:0] == 2'b10);

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_req_mask = 4'b0001 << req_addr[1:0];
            2'b01:   w_req_mask = req_addr[1] ? 4'b1100 : 4'b0011;
            default: w_req_mask = 4'b1111;
        endcase
    end

    // ---------------- read data lane select / extend / merge ----------------
    assign w_byte = mem_read_data[{r_lane, 3'b000} +: 8];
    assign w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = mem_read_data;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata[15:0];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)        w_next = S_RESP;
                    else if (w_is_sw) w_next = S_WR;
                    else              w_next = S_RD;
                end
            end
            S_RD:    w_next = r_store ? S_MERGE : S_LCAP;
            S_LCAP:  w_next = S_RESP;
            S_MERGE: w_next = S_WR;
            S_WR:    w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- registered outputs and request latch ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_sign_mask  <= 4'b0000;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_error     <= 1'b0;
            r_store        <= 1'b0;
            r_funct3       <= 3'd0;
            r_lane         <= 2'd0;
            r_wdata        <= 32'd0;
            r_mask         <= 4'd0;
        end else begin
            // Strobes and the mask are single-cycle unless re-asserted below.
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            mem_sign_mask <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_store    <= req_store;
                        r_funct3   <= req_funct3;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_mask     <= w_req_mask;
                        resp_rdata <= 32'd0;
                        resp_error <= w_err;
                        if (w_err) begin
                            resp_valid <= 1'b1;
                        end else if (w_is_sw) begin
                            mem_addr       <= w_req_word;
                            mem_memwrite   <= 1'b1;
                            mem_write_data <= req_wdata;
                            mem_sign_mask  <= 4'b1111;
                        end else begin
                            mem_addr      <= w_req_word;
                            mem_memread   <= 1'b1;
                            mem_sign_mask <= w_req_mask;
                        end
                    end
                end
                S_LCAP: begin
                    resp_rdata <= w_load_ext;
                    resp_valid <= 1'b1;
                end
                S_MERGE: begin
                    mem_memwrite   <= 1'b1;
                    mem_write_data <= w_merged;
                    mem_sign_mask  <= r_mask;
                end
                S_WR: begin
                    resp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
